// File: rtl/dawg_cache_pkg.sv
// Shared encodings for the DAWG partitioned cache set: replacement policy
// select values and the flush sequencer states.
package dawg_cache_pkg;

    localparam logic POL_NRU = 1'b0;
    localparam logic POL_RR  = 1'b1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FLUSH = 1'b1
    } state_e;

endpackage

// File: rtl/dawg_way_select.sv
// Priority finder over a way mask: lowest set bit, or (after_i=1) the first set
// bit strictly above ptr_i, wrapping to the lowest set bit.
module dawg_way_select #(
    parameter  int NUM_WAYS = 8,
    localparam int WAY_W    = $clog2(NUM_WAYS)
) (
    input  logic [NUM_WAYS-1:0] mask_i,
    input  logic [WAY_W-1:0]    ptr_i,
    input  logic                after_i,
    output logic                found_o,
    output logic [WAY_W-1:0]    idx_o
);

    logic             lo_f, nx_f;
    logic [WAY_W-1:0] lo_i, nx_i;

    always_comb begin
        lo_f = 1'b0;
        lo_i = '0;
        nx_f = 1'b0;
        nx_i = '0;
        for (int unsigned i = 0; i < NUM_WAYS; i++) begin
            if (mask_i[i] && !lo_f) begin
                lo_f = 1'b1;
                lo_i = WAY_W'(i);
            end
            if (mask_i[i] && (i > 32'(ptr_i)) && !nx_f) begin
                nx_f = 1'b1;
                nx_i = WAY_W'(i);
            end
        end
    end

    assign found_o = after_i ? (nx_f | lo_f) : lo_f;
    assign idx_o   = (after_i && nx_f) ? nx_i : lo_i;

endmodule

// File: rtl/dawg_cache_set.sv
// One set of a DAWG way-partitioned cache: partition-isolated lookup and fill
// with NRU or round-robin replacement, and a way-by-way partition flush.
module dawg_cache_set
    import dawg_cache_pkg::*;
#(
    parameter  int NUM_WAYS   = 8,
    parameter  int ADDR_WIDTH = 8,
    localparam int WAY_W      = $clog2(NUM_WAYS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  os_req,
    input  logic [NUM_WAYS-1:0]   os_hitmap,
    input  logic                  os_policy,
    input  logic                  flush_req,
    input  logic                  user_req,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic                  busy,
    output logic                  flush_done,
    output logic                  resp_valid,
    output logic                  hit,
    output logic [WAY_W-1:0]      hit_way,
    output logic                  evict_valid,
    output logic [ADDR_WIDTH-1:0] evict_tag,
    output logic [NUM_WAYS-1:0]   part_o,
    output logic [NUM_WAYS-1:0]   meta_o
);

    state_e                state_q, state_d;
    logic [WAY_W-1:0]      w_q, w_d, rr_q, rr_d;
    logic [NUM_WAYS-1:0]   part_q, part_d, valid_q, valid_d, meta_q, meta_d;
    logic                  pol_q, pol_d;
    logic [ADDR_WIDTH-1:0] tag_q [NUM_WAYS];
    logic [ADDR_WIDTH-1:0] tag_d [NUM_WAYS];

    logic                  resp_valid_q, resp_valid_d, hit_q, hit_d;
    logic                  evict_valid_q, evict_valid_d, flush_done_q, flush_done_d;
    logic [WAY_W-1:0]      hit_way_q, hit_way_d;
    logic [ADDR_WIDTH-1:0] evict_tag_q, evict_tag_d;

    logic [NUM_WAYS-1:0]   match;
    logic                  hit_found, nru_found, lo_found, nx_found, os_found;
    logic [WAY_W-1:0]      hit_idx, nru_idx, lo_idx, nx_idx, os_idx, victim;

    // match already excludes out-of-partition ways, so foreign lines never hit
    always_comb begin
        match = '0;
        for (int unsigned i = 0; i < NUM_WAYS; i++) begin
            match[i] = valid_q[i] && (tag_q[i] == addr) && part_q[i];
        end
    end

    dawg_way_select #(.NUM_WAYS(NUM_WAYS)) u_hit (
        .mask_i(match), .ptr_i('0), .after_i(1'b0),
        .found_o(hit_found), .idx_o(hit_idx)
    );
    dawg_way_select #(.NUM_WAYS(NUM_WAYS)) u_nru (
        .mask_i(part_q & ~meta_q), .ptr_i('0), .after_i(1'b0),
        .found_o(nru_found), .idx_o(nru_idx)
    );
    dawg_way_select #(.NUM_WAYS(NUM_WAYS)) u_lo (
        .mask_i(part_q), .ptr_i('0), .after_i(1'b0),
        .found_o(lo_found), .idx_o(lo_idx)
    );
    dawg_way_select #(.NUM_WAYS(NUM_WAYS)) u_rr (
        .mask_i(part_q), .ptr_i(rr_q), .after_i(1'b1),
        .found_o(nx_found), .idx_o(nx_idx)
    );
    dawg_way_select #(.NUM_WAYS(NUM_WAYS)) u_os (
        .mask_i(os_hitmap), .ptr_i('0), .after_i(1'b0),
        .found_o(os_found), .idx_o(os_idx)
    );

    always_comb begin
        state_d       = state_q;
        w_d           = w_q;
        rr_d          = rr_q;
        part_d        = part_q;
        pol_d         = pol_q;
        valid_d       = valid_q;
        meta_d        = meta_q;
        tag_d         = tag_q;
        victim        = '0;
        resp_valid_d  = 1'b0;
        hit_d         = 1'b0;
        hit_way_d     = '0;
        evict_valid_d = 1'b0;
        evict_tag_d   = '0;
        flush_done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (os_req) begin
                    part_d = os_hitmap;
                    pol_d  = os_policy ? POL_RR : POL_NRU;
                    rr_d   = os_found ? os_idx : '0;
                end else if (flush_req) begin
                    state_d = S_FLUSH;
                    w_d     = '0;
                end else if (user_req) begin
                    resp_valid_d = 1'b1;
                    if (lo_found && hit_found) begin
                        hit_d           = 1'b1;
                        hit_way_d       = hit_idx;
                        meta_d[hit_idx] = 1'b1;
                    end else if (lo_found) begin
                        if (pol_q == POL_NRU) begin
                            victim = nru_found ? nru_idx : lo_idx;
                            // saturated: age out the whole partition before marking the victim
                            if (!nru_found) meta_d = meta_q & ~part_q;
                            meta_d[victim] = 1'b1;
                        end else begin
                            victim = rr_q;
                            rr_d   = nx_found ? nx_idx : rr_q;
                        end
                        hit_way_d       = victim;
                        evict_valid_d   = valid_q[victim];
                        evict_tag_d     = valid_q[victim] ? tag_q[victim] : '0;
                        tag_d[victim]   = addr;
                        valid_d[victim] = 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                if (part_q[w_q]) begin
                    tag_d[w_q]   = '0;
                    valid_d[w_q] = 1'b0;
                    meta_d[w_q]  = 1'b0;
                end
                if (w_q == WAY_W'(NUM_WAYS - 1)) begin
                    state_d      = S_IDLE;
                    flush_done_d = 1'b1;
                end else begin
                    w_d = w_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            w_q           <= '0;
            rr_q          <= '0;
            part_q        <= '0;
            pol_q         <= POL_NRU;
            valid_q       <= '0;
            meta_q        <= '0;
            for (int unsigned i = 0; i < NUM_WAYS; i++) tag_q[i] <= '0;
            resp_valid_q  <= 1'b0;
            hit_q         <= 1'b0;
            hit_way_q     <= '0;
            evict_valid_q <= 1'b0;
            evict_tag_q   <= '0;
            flush_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            w_q           <= w_d;
            rr_q          <= rr_d;
            part_q        <= part_d;
            pol_q         <= pol_d;
            valid_q       <= valid_d;
            meta_q        <= meta_d;
            tag_q         <= tag_d;
            resp_valid_q  <= resp_valid_d;
            hit_q         <= hit_d;
            hit_way_q     <= hit_way_d;
            evict_valid_q <= evict_valid_d;
            evict_tag_q   <= evict_tag_d;
            flush_done_q  <= flush_done_d;
        end
    end

    assign busy        = (state_q == S_FLUSH);
    assign flush_done  = flush_done_q;
    assign resp_valid  = resp_valid_q;
    assign hit         = hit_q;
    assign hit_way     = hit_way_q;
    assign evict_valid = evict_valid_q;
    assign evict_tag   = evict_tag_q;
    assign part_o      = part_q;
    assign meta_o      = meta_q;

endmodule
